// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests and exception inputs in, stall/flush/redirect out.
// Optional perf-counter outputs exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ctrl_busy;
  logic        wdog_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

`ifdef PIPE_PERF_CNT_EN
  modport master (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, ctrl_busy, wdog_timeout,
    output perf_stall_cycles, perf_flush_count
  );
  modport slave (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, ctrl_busy, wdog_timeout,
    input  perf_stall_cycles, perf_flush_count
  );
`else
  modport master (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, ctrl_busy, wdog_timeout
  );
  modport slave (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, ctrl_busy, wdog_timeout
  );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Six-stage pipeline controller: stall merge (0-cycle), exception freeze->flush (flush 2 cycles after detect), stall watchdog.
// No backpressure of its own; PIPE_PERF_CNT_EN adds saturating stall/flush perf counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [31:0] ERET_TYPE  = 32'h0000_000e,
  parameter int          WDOG_LIMIT = 1024,
  parameter int          WDOG_W     = 11
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [WDOG_W-1:0] LP_WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_flush;
  logic [31:0]       r_new_pc;
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_to;
  logic [5:0]        w_stall;
  logic              w_exc;
  logic              w_enter_freeze;
  logic [31:0]       w_redirect;

  assign w_exc          = |bus.excepttype_i;
  assign w_enter_freeze = (r_state == ST_IDLE) && w_exc;
  assign w_redirect     = (bus.excepttype_i == ERET_TYPE) ? bus.cp0_epc_i : EXC_VECTOR;

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 6'b000000;
    case (r_state)
      ST_IDLE: begin
        if (w_exc) begin
          // Hold every stage so the faulting instruction cannot retire.
          w_state_nxt = ST_FREEZE;
          w_stall     = 6'b111111;
        end else if (bus.stallreq_from_mem) begin
          w_stall = 6'b011111;
        end else if (bus.stallreq_from_ex) begin
          w_stall = 6'b001111;
        end else if (bus.stallreq_from_id) begin
          w_stall = 6'b000111;
        end else if (bus.stallreq_from_if) begin
          w_stall = 6'b000011;
        end
      end
      ST_FREEZE: begin
        w_state_nxt = ST_FLUSH;
        w_stall     = 6'b111111;
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (rst) begin
      w_stall = 6'b000000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_flush  <= 1'b0;
      r_new_pc <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= (w_state_nxt == ST_FLUSH);
      if (w_enter_freeze) begin
        r_new_pc <= w_redirect;
      end
    end
  end

  // Counts only request-driven stalls in IDLE; exception freezes never trip it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog_to  <= 1'b0;
    end else begin
      r_wdog_to <= 1'b0;
      if (w_enter_freeze || (w_stall == 6'b000000)) begin
        r_wdog_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
        if (r_wdog_cnt == LP_WDOG_LAST) begin
          r_wdog_cnt <= '0;
          r_wdog_to  <= 1'b1;
        end else begin
          r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
        end
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = r_flush;
  assign bus.new_pc       = r_new_pc;
  assign bus.ctrl_busy    = (r_state != ST_IDLE);
  assign bus.wdog_timeout = r_wdog_to;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 32'h0;
      r_perf_flush <= 32'h0;
    end else begin
      if (w_stall[0] && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if ((r_state == ST_FLUSH) && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_flush_count  = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle reference model comparison plus hand-computed literal checks.
module tb_pipe_ctrl;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  pipe_ctrl_if bus();

  pipe_ctrl #(.WDOG_LIMIT(LIMIT), .WDOG_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: sequence phase (0 idle, 1 freeze, 2 flush) and a stalled-edge run length.
  int          m_phase;
  logic [31:0] m_newpc;
  int          m_run;
  logic        m_to;
  logic        m_valid;

  function automatic logic [5:0] model_stall();
    int n;
    n = 0;
    if (rst) return 6'd0;
    if (m_phase == 1 || (m_phase == 0 && bus.excepttype_i != 0)) return 6'b111111;
    if (m_phase == 2) return 6'd0;
    if (bus.stallreq_from_mem) n = 5;
    else if (bus.stallreq_from_ex) n = 4;
    else if (bus.stallreq_from_id) n = 3;
    else if (bus.stallreq_from_if) n = 2;
    return 6'((1 << n) - 1);
  endfunction

  always @(posedge clk) begin : model_upd
    int nr;
    if (rst) begin
      m_phase <= 0;
      m_newpc <= 32'h0;
      m_run   <= 0;
      m_to    <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      nr = 0;
      m_to <= 1'b0;
      if (m_phase == 0) begin
        if (bus.excepttype_i != 0) begin
          m_phase <= 1;
          m_newpc <= (bus.excepttype_i == 32'he) ? bus.cp0_epc_i : 32'h40;
        end else if (model_stall() != 0) begin
          nr = m_run + 1;
          if (nr == LIMIT) begin
            m_to <= 1'b1;
            nr = 0;
          end
        end
        m_run <= nr;
      end else if (m_phase == 1) begin
        m_phase <= 2;
        m_run   <= 0;
      end else begin
        m_phase <= 0;
        m_run   <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      chk("mdl_stall", 32'(bus.stall), 32'(model_stall()));
      chk("mdl_flush", 32'(bus.flush), 32'(m_phase == 2));
      chk("mdl_new_pc", bus.new_pc, m_newpc);
      chk("mdl_busy", 32'(bus.ctrl_busy), 32'(m_phase != 0));
      chk("mdl_wdog", 32'(bus.wdog_timeout), 32'(m_to));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    bus.stallreq_from_if  = r_if;
    bus.stallreq_from_id  = r_id;
    bus.stallreq_from_ex  = r_ex;
    bus.stallreq_from_mem = r_mem;
  endtask

  logic [11:0] wd_pat;
  logic [11:0] wd_exp;
  logic [9:0]  gap_pat;
  logic [9:0]  gap_exp;

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    m_valid = 1'b0;
    m_phase = 0;
    m_newpc = 32'h0;
    m_run   = 0;
    m_to    = 1'b0;
    rst     = 1'b1;
    set_req(1'b1, 1'b1, 1'b1, 1'b1);
    bus.excepttype_i = 32'h1;
    bus.cp0_epc_i    = 32'h0;

    // Reset dominates every request and exception.
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rst_stall", 32'(bus.stall), 32'h0);
      chk("rst_flush", 32'(bus.flush), 32'h0);
      chk("rst_new_pc", bus.new_pc, 32'h0);
      chk("rst_busy", 32'(bus.ctrl_busy), 32'h0);
      nxt();
    end
    rst = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus.excepttype_i = 32'h0;

    // Stall priority.
    nxt();
    set_req(1'b0, 1'b1, 1'b1, 1'b0);
    mid(); chk("prio_id_ex", 32'(bus.stall), 32'h0f);
    nxt(); set_req(1'b0, 1'b1, 1'b0, 1'b0);
    mid(); chk("prio_id", 32'(bus.stall), 32'h07);
    nxt(); set_req(1'b1, 1'b0, 1'b0, 1'b0);
    mid(); chk("prio_if", 32'(bus.stall), 32'h03);
    nxt(); set_req(1'b0, 1'b0, 1'b0, 1'b0);
    mid(); chk("prio_none", 32'(bus.stall), 32'h00);

    // Syscall with concurrent MEM request.
    nxt(); bus.excepttype_i = 32'h8; set_req(1'b0, 1'b0, 1'b0, 1'b1);
    mid(); chk("sys_det_stall", 32'(bus.stall), 32'h3f);
    chk("sys_det_busy", 32'(bus.ctrl_busy), 32'h0);
    nxt(); bus.excepttype_i = 32'h0;
    mid(); chk("sys_frz_stall", 32'(bus.stall), 32'h3f);
    chk("sys_frz_flush", 32'(bus.flush), 32'h0);
    chk("sys_frz_busy", 32'(bus.ctrl_busy), 32'h1);
    nxt();
    mid(); chk("sys_fl_flush", 32'(bus.flush), 32'h1);
    chk("sys_fl_pc", bus.new_pc, 32'h40);
    chk("sys_fl_stall", 32'(bus.stall), 32'h0);
    nxt();
    mid(); chk("sys_end_flush", 32'(bus.flush), 32'h0);
    chk("sys_end_busy", 32'(bus.ctrl_busy), 32'h0);
    chk("sys_end_stall", 32'(bus.stall), 32'h1f);
    nxt(); set_req(1'b0, 1'b0, 1'b0, 1'b0);

    // ERET, with EPC changing during FREEZE.
    bus.excepttype_i = 32'he; bus.cp0_epc_i = 32'h8000_1234;
    mid(); chk("eret_det_stall", 32'(bus.stall), 32'h3f);
    nxt(); bus.excepttype_i = 32'h0; bus.cp0_epc_i = 32'hdead_beef;
    mid(); chk("eret_frz_flush", 32'(bus.flush), 32'h0);
    nxt();
    mid(); chk("eret_fl_flush", 32'(bus.flush), 32'h1);
    chk("eret_fl_pc", bus.new_pc, 32'h8000_1234);
    nxt();
    mid(); chk("eret_hold_pc", bus.new_pc, 32'h8000_1234);
    chk("eret_end_flush", 32'(bus.flush), 32'h0);

    // Reset during FREEZE aborts the sequence.
    nxt(); bus.excepttype_i = 32'h8;
    mid(); chk("abort_det", 32'(bus.stall), 32'h3f);
    nxt(); bus.excepttype_i = 32'h0; rst = 1'b1;
    mid(); chk("abort_frz_busy", 32'(bus.ctrl_busy), 32'h1);
    chk("abort_frz_stall", 32'(bus.stall), 32'h0);
    nxt(); rst = 1'b0;
    mid(); chk("abort_flush", 32'(bus.flush), 32'h0);
    chk("abort_busy", 32'(bus.ctrl_busy), 32'h0);
    chk("abort_pc", bus.new_pc, 32'h0);
    nxt();
    mid(); chk("abort_flush2", 32'(bus.flush), 32'h0);

    // Exception held through FLUSH restarts only in the following IDLE cycle.
    bus.excepttype_i = 32'h4; set_req(1'b0, 1'b0, 1'b1, 1'b0);
    nxt();
    mid(); chk("hold_frz_busy", 32'(bus.ctrl_busy), 32'h1);
    nxt();
    mid(); chk("hold_fl_flush", 32'(bus.flush), 32'h1);
    chk("hold_fl_stall", 32'(bus.stall), 32'h0);
    nxt();
    mid(); chk("hold_re_busy", 32'(bus.ctrl_busy), 32'h0);
    chk("hold_re_stall", 32'(bus.stall), 32'h3f);
    nxt(); bus.excepttype_i = 32'h0; set_req(1'b0, 1'b0, 1'b0, 1'b0);
    mid(); chk("hold_re_frz", 32'(bus.ctrl_busy), 32'h1);
    nxt();
    mid(); chk("hold_re_flush", 32'(bus.flush), 32'h1);
    nxt(); nxt();

    // Watchdog: EX request held across 10 edges pulses after the 4th and 8th.
    wd_pat = 12'b0000_1111_1111 | 12'b0011_0000_0000;
    wd_exp = 12'b0001_0001_0000;
    for (int c = 0; c < 12; c++) begin
      nxt();
      bus.stallreq_from_ex = wd_pat[c];
      mid();
      chk("wdog_run", 32'(bus.wdog_timeout), 32'(wd_exp[c]));
    end

    // A one-cycle gap restarts the count.
    gap_pat = 10'b00_1111_0111;
    gap_exp = 10'b01_0000_0000;
    for (int c = 0; c < 10; c++) begin
      nxt();
      bus.stallreq_from_ex = gap_pat[c];
      mid();
      chk("wdog_gap", 32'(bus.wdog_timeout), 32'(gap_exp[c]));
    end

    nxt(); nxt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the six-stage pipeline: PC, IF, ID, EX, MEM and WB.
- Merges per-stage stall requests into the `stall[5:0]` vector consumed by every pipeline register.
- Sequences exception/ERET recovery: freeze for one cycle, then a one-cycle registered flush with a latched redirect PC.
- Runs a stall watchdog.
- Sits beside the pipeline registers and drives only control signals.

Parameters:
- EXC_VECTOR, 32'h00000040, common exception entry PC.
- ERET_TYPE, 32'h0000000e, excepttype_i code meaning ERET; redirect target is cp0_epc_i.
- WDOG_LIMIT, 1024, consecutive stalled cycles before wdog_timeout pulses.
- WDOG_W, 11, watchdog counter width; must satisfy 2^WDOG_W > WDOG_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_from_if  in  1  IF stage needs a hold.
- stallreq_from_id  in  1  ID stage needs a hold (load-use, etc.).
- stallreq_from_ex  in  1  EX stage needs a hold (multi-cycle mul/div).
- stallreq_from_mem  in  1  MEM stage needs a hold (multi-clock access).
- excepttype_i  in  32  MEM-stage exception type; 0 = none.
- cp0_epc_i  in  32  current EPC from CP0.
- stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop.
- flush  out  1  registered flush to all pipeline registers.
- new_pc  out  32  registered redirect target, valid while flush=1.
- ctrl_busy  out  1  FSM not in IDLE.
- wdog_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, flush=0, new_pc=0, wdog count=0, wdog_timeout=0.
  - stall output is 6'b000000 while rst=1 (combinational override).
  - Reset mid-sequence (FREEZE or FLUSH) aborts to IDLE; no flush is emitted.
- FSM states: IDLE, FREEZE, FLUSH.
  - IDLE -> FREEZE: when excepttype_i != 0. At that edge, latch new_pc = (excepttype_i==ERET_TYPE) ? cp0_epc_i : EXC_VECTOR.
  - FREEZE -> FLUSH: unconditional, 1 cycle.
  - FLUSH -> IDLE: unconditional, 1 cycle.
- Stall vector (combinational from state and requests):
  - In the detection cycle (IDLE with excepttype_i != 0) and in FREEZE: stall=6'b111111, so no stage advances and the faulting instruction does not reach WB.
  - In FLUSH: stall=6'b000000; all stall requests are ignored.
  - In IDLE with no exception, fixed priority MEM > EX > ID > IF:
    - mem: 6'b011111
    - ex: 6'b001111
    - id: 6'b000111
    - if: 6'b000011
    - none: 6'b000000
- Flush and redirect:
  - flush is a registered output, 1 exactly while state==FLUSH.
  - new_pc holds its latched value until the next latch; it is not cleared on leaving FLUSH.
  - excepttype_i is ignored in FREEZE and FLUSH. Back-to-back exceptions are handled one sequence at a time; an exception present in the first IDLE cycle after FLUSH starts a new sequence.
- ctrl_busy = (state != IDLE).
- Watchdog:
  - Counter increments on each edge where stall != 0 in IDLE.
  - Clears on any edge with stall == 0, and on entry to FREEZE.
  - When count == WDOG_LIMIT-1 and still stalled, wdog_timeout=1 next cycle for exactly one cycle, then the counter restarts at 0.
  - Counter never wraps silently.
- No other latency: stall responds in the same cycle as the requests.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Extra outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], both registered and reset to 0.
  - perf_stall_cycles += 1 on each edge where stall[0]==1.
  - perf_flush_count += 1 on each edge where state==FLUSH.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset priority: rst=1 for 3 cycles with all stallreqs=1 and excepttype_i=1 -> stall=0, flush=0, new_pc=0, ctrl_busy=0.
- Stall priority: stallreq_from_id=1 and stallreq_from_ex=1 together -> stall=6'b001111. Drop ex only -> stall=6'b000111 the same cycle. Drop all -> 6'b000000.
- Syscall exception: excepttype_i=32'h8 for 1 cycle, stallreq_from_mem=1 concurrently.
  - Detection cycle: stall=6'b111111.
  - FREEZE cycle: stall=6'b111111.
  - Next cycle: flush=1, new_pc=32'h40, stall=0.
  - Following cycle: flush=0, ctrl_busy=0, stall=6'b011111 (mem request still high).
- ERET: excepttype_i=32'he, cp0_epc_i=32'h80001234 -> flush=1 two cycles later with new_pc=32'h80001234. Change cp0_epc_i during FREEZE -> new_pc unchanged.
- Reset mid-sequence and ignored exception:
  - Assert rst during FREEZE -> no flush pulse; state returns to IDLE.
  - Separately, excepttype_i held nonzero during FLUSH -> a second sequence starts only in the following IDLE cycle.
- Watchdog with WDOG_LIMIT=4: stallreq_from_ex held 10 cycles -> wdog_timeout pulses after the 4th and 8th stalled edges. A one-cycle gap in the request resets the count.
